timer_scheduler: RTL and testbench

Four-channel millisecond timer controller for the ez8 peripheral bus. It shares one free-running millisecond prescaler among four independent 8-bit countdown channels, each with an optional auto-reload. Per-channel expiry is latched into pending flags, which drive a single maskable interrupt line to the processor. It sits on the memory-mapped peripheral bus beside the other I/O blocks and gives software multiple concurrent ms timeouts without duplicating the 16-bit prescaler.

---
 rtl/timer_scheduler.sv | 132 +++++++++++++
 tb/tb_timer_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// timer_scheduler: four 8-bit millisecond countdown channels sharing one
// free-running prescaler, with per-channel auto-reload, latched pending
// flags and a single maskable level interrupt. Bus-mapped register file.
module timer_scheduler #(
  parameter logic [15:0] TICK_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] addr,
  input  logic [7:0] wr_data,
  input  logic       write,
  output logic [7:0] rd_data,
  output logic [3:0] expired,
  output logic       irq
);

  localparam int unsigned NCH = 4;

  localparam logic [2:0] A_CTRL = 3'd4;
  localparam logic [2:0] A_PEND = 3'd5;
  localparam logic [2:0] A_RSVD = 3'd6;
  localparam logic [2:0] A_STAT = 3'd7;

  logic [15:0]          presc_q, presc_d;
  logic                 tick;
  logic [NCH-1:0][7:0]  count_q, count_d;
  logic [NCH-1:0][7:0]  reload_q, reload_d;
  logic [7:0]           ctrl_q, ctrl_d;
  logic [NCH-1:0]       pend_q, pend_d;
  logic [NCH-1:0]       pend_set;
  logic [7:0]           rd_q, rd_d;

  logic [NCH-1:0]       reload_en;
  logic [NCH-1:0]       irq_en;

  assign reload_en = ctrl_q[3:0];
  assign irq_en    = ctrl_q[7:4];

  // Free-running prescaler; a tick is the cycle the counter sits at zero.
  assign tick = (presc_q == 16'd0);

  // Prescaler next state: reload on wrap, otherwise count down.
  always_comb begin
    presc_d = presc_q - 16'd1;
    if (tick) begin
      presc_d = TICK_CYCLES - 16'd1;
    end
  end

  // Channel countdown, reload and pending-set logic; a CNTn write overrides
  // the channel's tick behaviour in the same cycle.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    pend_set = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (tick && (count_q[n] != 8'd0)) begin
        if (count_q[n] > 8'd1) begin
          count_d[n] = count_q[n] - 8'd1;
        end else begin
          pend_set[n] = 1'b1;
          count_d[n]  = reload_en[n] ? reload_q[n] : 8'd0;
        end
      end
      if (write && (addr == 3'(n))) begin
        count_d[n]  = wr_data;
        reload_d[n] = wr_data;
        pend_set[n] = 1'b0;
      end
    end
  end

  // Control register update.
  always_comb begin
    ctrl_d = ctrl_q;
    if (write && (addr == A_CTRL)) begin
      ctrl_d = wr_data;
    end
  end

  // Pending flags: write-1-to-clear, with a new expiry taking priority.
  always_comb begin
    pend_d = pend_q;
    if (write && (addr == A_PEND)) begin
      pend_d = pend_d & ~wr_data[3:0];
    end
    pend_d = pend_d | pend_set;
  end

  // Read mux, sampled into the registered read port every cycle.
  always_comb begin
    rd_d = '0;
    case (addr)
      3'd0, 3'd1, 3'd2, 3'd3: rd_d = count_q[addr[1:0]];
      A_CTRL:                 rd_d = ctrl_q;
      A_PEND:                 rd_d = {4'b0, pend_q};
      A_RSVD:                 rd_d = '0;
      A_STAT:                 rd_d = {4'b0, expired};
      default:                rd_d = '0;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= TICK_CYCLES - 16'd1;
      count_q  <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      pend_q   <= '0;
      rd_q     <= '0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      rd_q     <= rd_d;
    end
  end

  // Status outputs derived directly from registered state.
  always_comb begin
    for (int unsigned n = 0; n < NCH; n++) begin
      expired[n] = (count_q[n] == 8'd0);
    end
  end

  assign irq     = |(pend_q & irq_en);
  assign rd_data = rd_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with TICK_CYCLES=10. The bench tracks
// clock edges since the last reset edge; ticks take effect at edges 10,20,...
module tb_timer_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wr_data = '0;
  logic       write = 1'b0;
  logic [7:0] rd_data;
  logic [3:0] expired;
  logic       irq;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  timer_scheduler #(.TICK_CYCLES(16'd10)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wr_data(wr_data),
    .write(write),
    .rd_data(rd_data),
    .expired(expired),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned t);
    while (cyc < t) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a;
    wr_data = d;
    write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    write = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  logic [7:0] exp_rd [8];

  initial begin
    exp_rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};

    // Reset state and full register map readback
    do_reset();
    check("rst_expired", {4'b0, expired}, 8'h0F);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_rd", rd_data, 8'h00);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      step();
      check($sformatf("rst_read_%0d", a), rd_data, exp_rd[a]);
    end

    // One-shot on channel 0 with irq enabled: expiry on the 3rd tick (edge 40)
    wr(3'd4, 8'h10);
    run_to(10);
    wr(3'd0, 8'd3);
    run_to(39);
    check("ch0_pre_irq", {7'b0, irq}, 8'h00);
    check("ch0_pre_exp", {4'b0, expired}, 8'h0E);
    step();
    check("ch0_irq", {7'b0, irq}, 8'h01);
    check("ch0_exp", {4'b0, expired}, 8'h0F);
    addr = 3'd5;
    step();
    check("ch0_pend", rd_data, 8'h01);
    wr(3'd5, 8'h01);
    check("ch0_clr_irq", {7'b0, irq}, 8'h00);

    // Auto-reload on channel 1: expiries at edges 60, 80
    wr(3'd4, 8'h22);
    wr(3'd1, 8'd2);
    addr = 3'd1;
    run_to(51);
    check("ch1_cnt_a", rd_data, 8'd1);
    run_to(59);
    check("ch1_pre_irq", {7'b0, irq}, 8'h00);
    check("ch1_pre_exp", {4'b0, expired}, 8'h0D);
    step();
    check("ch1_irq", {7'b0, irq}, 8'h01);
    check("ch1_exp_held", {4'b0, expired}, 8'h0D);
    step();
    check("ch1_cnt_reload", rd_data, 8'd2);
    run_to(71);
    check("ch1_cnt_b", rd_data, 8'd1);
    wr(3'd5, 8'h02);
    check("ch1_clr_irq", {7'b0, irq}, 8'h00);
    run_to(79);
    check("ch1_pre_irq2", {7'b0, irq}, 8'h00);
    step();
    check("ch1_irq2", {7'b0, irq}, 8'h01);

    // CNT2 write on the tick edge: write wins, no decrement, no pending
    run_to(89);
    wr(3'd2, 8'd5);
    step();
    check("ch2_cnt_on_tick", rd_data, 8'd5);
    addr = 3'd5;
    step();
    check("ch2_no_pend", rd_data, 8'h02);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd0);
    check("disarm_exp", {4'b0, expired}, 8'h0F);

    // Channel 3 expiry coinciding with PEND clear of bits 3 and 0
    wr(3'd0, 8'd1);
    wr(3'd3, 8'd2);
    addr = 3'd5;
    run_to(101);
    check("ch3_pend_pre", rd_data, 8'h03);
    check("ch3_exp_pre", {4'b0, expired}, 8'h07);
    run_to(109);
    wr(3'd5, 8'h09);
    step();
    check("ch3_set_wins", rd_data, 8'h0A);
    check("ch3_exp_post", {4'b0, expired}, 8'h0F);

    // Reset mid-count
    wr(3'd4, 8'h00);
    wr(3'd0, 8'd4);
    addr = 3'd0;
    run_to(131);
    check("mid_cnt", rd_data, 8'd2);
    check("mid_exp", {4'b0, expired}, 8'h0E);
    do_reset();
    check("mid_rst_rd", rd_data, 8'h00);
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
    check("mid_rst_exp", {4'b0, expired}, 8'h0F);
    wr(3'd0, 8'd1);
    check("post_rst_cnt0", rd_data, 8'h00);
    addr = 3'd5;
    step();
    check("post_rst_pend", rd_data, 8'h00);
    addr = 3'd4;
    step();
    check("post_rst_ctrl", rd_data, 8'h00);

    // Prescaler restarted by reset: first tick lands on edge 10
    run_to(9);
    check("presc_pre", {4'b0, expired}, 8'h0E);
    step();
    check("presc_tick", {4'b0, expired}, 8'h0F);
    addr = 3'd5;
    step();
    check("presc_pend", rd_data, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
